req_ack_responder: RTL and testbench

// - Downstream partner of the req/ack requester: watches its 4-phase-lite req, returns a one-cycle ack.
// - Programmable latency per transaction.
// - Counts completed transactions and flags protocol violations by the requester.
// - Sits between the requester and the (modelled) target resource.
// - Used in simulation benches and on the FPGA to close the req/ack loop.

---
 rtl/req_ack_pkg.sv | 15 +
 rtl/req_ack_lat_cnt.sv | 41 ++++
 rtl/req_ack_responder.sv | 113 +++++++++++
 tb/tb_req_ack_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/req_ack_pkg.sv
// rtl/req_ack_pkg.sv - shared req/ack state encoding and default widths
// Used by the responder and by the requester side benches.
package req_ack_pkg;

    localparam int LAT_W_DEF = 4;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

endpackage

// File: rtl/req_ack_lat_cnt.sv
// rtl/req_ack_lat_cnt.sv - loadable latency down-counter for the req/ack responder
// Ports:
//   clk, reset_n  clock, synchronous active-low reset (counter clears to 0)
//   load          load load_val this cycle (has priority over dec)
//   load_val      value to load
//   dec           decrement by one
//   is_one        counter currently holds 1
module req_ack_lat_cnt #(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_one = (cnt_q == {{(LAT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/req_ack_responder.sv
// rtl/req_ack_responder.sv - req/ack responder with programmable latency, txn counter and sticky protocol error
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   req           request from requester, held until ack is sampled
//   lat_cfg       extra wait cycles, captured only on acceptance in IDLE
//   err_clr       clears proto_err (a simultaneous new error wins)
//   ack           one-cycle acknowledge, decoded from registered state
//   busy          request accepted and not yet acknowledged (WAIT or ACK)
//   txn_count     completed handshakes, wraps silently
//   proto_err     sticky requester protocol violation
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int LAT_W = LAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req,
    input  logic [LAT_W-1:0] lat_cfg,
    input  logic             err_clr,
    output logic             ack,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count,
    output logic             proto_err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] txn_count_q, txn_count_d;
    logic             proto_err_q, proto_err_d;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_is_one;
    logic err_set;
    logic txn_done;

    req_ack_lat_cnt #(
        .LAT_W (LAT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (lat_cfg),
        .dec      (cnt_dec),
        .is_one   (cnt_is_one)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        err_set  = 1'b0;
        txn_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    cnt_load = 1'b1;
                    state_d  = (lat_cfg == '0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Requester withdrew before ack: abort without counting.
                if (!req) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_is_one) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_ACK: begin
                if (req) begin
                    txn_done = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // A req still high here is stale; wait it out, never re-ack it.
                if (!req) begin
                    state_d = ST_IDLE;
                end else begin
                    err_set = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        txn_count_d = txn_done ? txn_count_q + 1'b1 : txn_count_q;
        proto_err_d = err_set | (proto_err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            txn_count_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            txn_count_q <= txn_count_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign ack       = (state_q == ST_ACK);
    assign busy      = (state_q == ST_WAIT) || (state_q == ST_ACK);
    assign txn_count = txn_count_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// tb/tb_req_ack_responder.sv - self-checking bench for req_ack_responder
module tb_req_ack_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic [3:0]  lat_cfg = 4'd0;
    logic        err_clr = 1'b0;
    logic        ack;
    logic        busy;
    logic [15:0] txn_count;
    logic        proto_err;

    int passed = 0;
    int total  = 0;

    req_ack_responder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .lat_cfg   (lat_cfg),
        .err_clr   (err_clr),
        .ack       (ack),
        .busy      (busy),
        .txn_count (txn_count),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    // Standard requester: drops req on the edge where it samples ack, raises it otherwise.
    logic ack_at_edge = 1'b0;
    bit   auto_req = 1'b0;
    always @(posedge clk) ack_at_edge <= ack;

    // Reference model: tracks the transaction by edge numbers, not a counter.
    int          edge_n = 0;
    int          m_due = 0;
    bit          m_pend = 0, m_ack = 0, m_rel = 0, m_err = 0;
    logic [15:0] m_cnt = 16'd0;
    int          preload_tok = 0;
    int          preload_seen = 0;
    logic [15:0] preload_val = 16'd0;

    always @(posedge clk) begin
        bit set_err;
        bit nxt_ack;
        if (preload_tok != preload_seen) begin
            m_cnt = preload_val;
            preload_seen = preload_tok;
        end
        if (!reset_n) begin
            m_pend = 0; m_ack = 0; m_rel = 0; m_err = 0; m_cnt = 16'd0;
        end else begin
            set_err = 0;
            nxt_ack = 0;
            if (m_ack) begin
                if (req) m_cnt = m_cnt + 16'd1;
                else set_err = 1;
                m_rel = 1;
            end else if (m_rel) begin
                if (!req) m_rel = 0;
                else set_err = 1;
            end else if (m_pend) begin
                if (!req) begin
                    set_err = 1;
                    m_pend = 0;
                end else if (edge_n == m_due) begin
                    m_pend = 0;
                    nxt_ack = 1;
                end
            end else if (req) begin
                if (lat_cfg == 4'd0) nxt_ack = 1;
                else begin
                    m_pend = 1;
                    m_due = edge_n + int'(lat_cfg);
                end
            end
            m_ack = nxt_ack;
            m_err = set_err | (m_err & !err_clr);
        end
        edge_n++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock: edge, then settle to the negedge and compare against the model.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        chk("model{ack,busy,err,cnt}", {13'd0, ack, busy, proto_err, txn_count},
            {13'd0, m_ack, (m_pend | m_ack), m_err, m_cnt});
        if (auto_req) req = !ack_at_edge;
    endtask

    typedef struct {
        logic        req;
        logic [3:0]  lat;
        logic        clr;
        logic        e_ack;
        logic        e_busy;
        logic        e_err;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n_ack;
        int n_busy;
        int n;

        // Reset for three cycles.
        for (int i = 0; i < 3; i++) cyc();
        chk("reset_state", {ack, busy, proto_err, txn_count}, 19'd0);

        // Requester attached, lat_cfg=0: period 3.
        reset_n = 1'b1;
        auto_req = 1'b1;
        req = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (ack) n_ack++;
        end
        chk("lat0_txn_count", txn_count, 16'd10);
        chk("lat0_ack_pulses", n_ack, 10);

        // lat_cfg=3: period 6, busy 4 of 6.
        lat_cfg = 4'd3;
        n_busy = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (busy) n_busy++;
        end
        chk("lat3_txn_count", txn_count, 16'd20);
        chk("lat3_busy_cycles", n_busy, 40);
        chk("lat3_no_err", proto_err, 1'b0);

        // Table: lat_cfg=5, req dropped in the 2nd WAIT cycle, then err_clr.
        auto_req = 1'b0;
        vecs[0] = '{1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 16'd20};
        vecs[1] = '{1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 16'd20};
        vecs[2] = '{1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20};
        vecs[3] = '{1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20};
        vecs[4] = '{1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 16'd20};
        for (int i = 0; i < 5; i++) begin
            req = vecs[i].req;
            lat_cfg = vecs[i].lat;
            err_clr = vecs[i].clr;
            cyc();
            chk($sformatf("abort_vec%0d{ack,busy,err,cnt}", i),
                {13'd0, ack, busy, proto_err, txn_count},
                {13'd0, vecs[i].e_ack, vecs[i].e_busy, vecs[i].e_err, vecs[i].e_cnt});
        end
        err_clr = 1'b0;

        // req held three cycles past ack.
        lat_cfg = 4'd0;
        req = 1'b1;
        n_ack = 0;
        cyc(); if (ack) n_ack++;
        for (int i = 0; i < 3; i++) begin
            cyc(); if (ack) n_ack++;
        end
        chk("hold_busy_in_release", busy, 1'b0);
        req = 1'b0;
        cyc(); if (ack) n_ack++;
        chk("hold_single_ack", n_ack, 1);
        chk("hold_err", proto_err, 1'b1);
        chk("hold_cnt", txn_count, 16'd21);
        req = 1'b1;
        cyc();
        chk("hold_reaccept_from_idle", ack, 1'b1);
        cyc();
        req = 1'b0;
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("err_clr", proto_err, 1'b0);
        cyc();

        // Counter wrap.
        force dut.txn_count_q = 16'hFFFE;
        release dut.txn_count_q;
        preload_val = 16'hFFFE;
        preload_tok++;
        auto_req = 1'b1;
        req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            if (i == 1) chk("wrap_ffff", txn_count, 16'hFFFF);
            if (i == 4) chk("wrap_0000", txn_count, 16'h0000);
            if (i == 7) chk("wrap_0001", txn_count, 16'h0001);
        end
        auto_req = 1'b0;

        // Reset in WAIT, then a full-latency transaction.
        lat_cfg = 4'd7;
        req = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        reset_n = 1'b0;
        cyc();
        chk("midreset_state", {ack, busy, proto_err, txn_count}, 19'd0);
        reset_n = 1'b1;
        n = 0;
        while (!ack && n < 20) begin
            cyc();
            n++;
        end
        chk("midreset_latency_edges", n, 8);
        cyc();
        req = 1'b0;
        cyc();
        chk("midreset_cnt", txn_count, 16'd1);
        chk("midreset_err", proto_err, 1'b0);

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset_n = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 9) < 3) req = $urandom_range(0, 1);
            lat_cfg = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            err_clr = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
